// File: rtl/prv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : prv32_mem_arbiter
// Description : Two-master arbiter for the PicoRV32 native memory bus.
//               Master 0 is the CPU core, master 1 the UART loader/DMA path.
//               One transaction at a time; grant is held until the slave
//               completes, the owner drops valid, or the optional watchdog
//               forces completion.
// Options     : PRV32_ARB_TIMEOUT_EN - enables the busy-cycle watchdog,
//               the sticky err_flag and err_clr.
// Revision    : 1.0 - initial release
// ============================================================================
module prv32_mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // master 0 (core)
  input  logic                    m0_valid,
  input  logic                    m0_instr,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic                    m0_ready,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  // master 1 (debug loader / DMA)
  input  logic                    m1_valid,
  input  logic                    m1_instr,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic                    m1_ready,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  // slave side
  output logic                    s_valid,
  output logic                    s_instr,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  // status
  output logic [1:0]              grant,
  output logic                    err_flag,
  input  logic                    err_clr
);

  localparam logic [DATA_WIDTH-1:0] c_TIMEOUT_DATA = DATA_WIDTH'(32'hDEADBEEF);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_grant;
  logic [1:0] w_grant_nxt;
  logic       r_last;        // index of the master granted most recently
  logic       w_last_nxt;
  logic       w_pick;        // index of the master chosen in IDLE
  logic       w_sel_valid;   // valid of the current owner
  logic       w_timeout;     // watchdog limit reached this cycle
  logic       w_err_set;     // watchdog forced a completion this cycle

  assign grant = r_grant;

  // State, owner and round-robin history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;       // master 0 wins the first tie after reset
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Arbitration, completion handling and bus muxing
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_pick      = 1'b0;
    w_sel_valid = 1'b0;
    w_err_set   = 1'b0;
    s_valid     = 1'b0;
    s_instr     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_rdata    = '0;
    m1_rdata    = '0;

    case (r_state)
      ST_IDLE: begin
        if (m0_valid || m1_valid) begin
          if (m0_valid && m1_valid) begin
            w_pick = (ROUND_ROBIN != 0) ? ~r_last : 1'b0;
          end else begin
            w_pick = m1_valid;
          end
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_pick ? 2'b10 : 2'b01;
          w_last_nxt  = w_pick;
        end
      end

      ST_BUSY: begin
        w_sel_valid = r_grant[1] ? m1_valid : m0_valid;
        s_instr     = r_grant[1] ? m1_instr : m0_instr;
        s_addr      = r_grant[1] ? m1_addr  : m0_addr;
        s_wdata     = r_grant[1] ? m1_wdata : m0_wdata;
        s_wstrb     = r_grant[1] ? m1_wstrb : m0_wstrb;
        // a forced completion withdraws the request from the slave
        s_valid     = w_sel_valid && !w_timeout;

        if (s_ready) begin
          // slave completion beats the watchdog in the same cycle
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 2'b00;
          if (r_grant[1]) begin
            m1_ready = 1'b1;
            m1_rdata = s_rdata;
          end else begin
            m0_ready = 1'b1;
            m0_rdata = s_rdata;
          end
        end else if (!w_sel_valid) begin
          // owner withdrew its request: abort without a ready
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 2'b00;
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 2'b00;
          w_err_set   = 1'b1;
          if (r_grant[1]) begin
            m1_ready = 1'b1;
            m1_rdata = c_TIMEOUT_DATA;
          end else begin
            m0_ready = 1'b1;
            m0_rdata = c_TIMEOUT_DATA;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

`ifdef PRV32_ARB_TIMEOUT_EN
  // counter only needs to reach TIMEOUT_CYCLES-1: the limit cycle itself ends BUSY
  localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT_CYCLES - 1);

  logic [c_TW-1:0] r_tcnt;
  logic            r_err;

  assign w_timeout = (r_state == ST_BUSY) && !s_ready && (r_tcnt == c_TLIM);
  assign err_flag  = r_err;

  // Busy-cycle counter, cleared whenever the arbiter is (or returns to) idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_state_nxt == ST_IDLE) begin
      r_tcnt <= '0;
    end else if ((r_state == ST_BUSY) && !s_ready) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // Sticky error flag; a clear request wins over a simultaneous set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign err_flag     = 1'b0;
  assign w_unused_cfg = err_clr | w_err_set | (TIMEOUT_CYCLES == 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_prv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prv32_mem_arbiter
// Description : Self-checking bench for prv32_mem_arbiter. A round-robin and
//               a fixed-priority instance share all inputs. Define
//               PRV32_ARB_TIMEOUT_EN to cover the watchdog (limit 8 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prv32_mem_arbiter;

  localparam int c_TOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_valid = 1'b0, m0_instr = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_wstrb = '0;
  logic        m1_valid = 1'b0, m1_instr = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_wstrb = '0;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        err_clr = 1'b0;

  logic        m0_ready, m1_ready, s_valid, s_instr, err_flag;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_instr, fp_err_flag;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_wstrb;
  logic [1:0]  fp_grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prv32_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(c_TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant), .err_flag(err_flag), .err_clr(err_clr)
  );

  prv32_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(c_TOUT)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_instr(fp_s_instr), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_wstrb(fp_s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(fp_grant), .err_flag(fp_err_flag), .err_clr(err_clr)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; err_clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1;
    step();
    step();
    n_checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b s_valid=%b m0_ready=%b m1_ready=%b err=%b, expected 00 0 0 0 0",
               grant, s_valid, m0_ready, m1_ready, err_flag);
    end
    apply_reset();
    step();
    n_checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: grant=%b s_valid=%b, expected 00 0", grant, s_valid);
    end
  endtask

  task automatic test_single_read();
    m0_valid = 1'b1; m0_instr = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = '0; m0_wstrb = 4'b0000;
    step();
    n_checks++;
    if (grant !== 2'b01 || s_valid !== 1'b1 || s_addr !== 32'h100 || s_instr !== 1'b1 || m0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL read_grant: grant=%b s_valid=%b s_addr=%h s_instr=%b m0_ready=%b, expected 01 1 00000100 1 0",
               grant, s_valid, s_addr, s_instr, m0_ready);
    end
    step();
    n_checks++;
    if (m0_ready !== 1'b0 || grant !== 2'b01) begin
      n_fail++;
      $display("FAIL read_wait: m0_ready=%b grant=%b, expected 0 01", m0_ready, grant);
    end
    step();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    n_checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h1234_5678 || m1_ready !== 1'b0 || m1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL read_complete: m0_ready=%b m0_rdata=%h m1_ready=%b m1_rdata=%h, expected 1 12345678 0 00000000",
               m0_ready, m0_rdata, m1_ready, m1_rdata);
    end
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b00 || m0_ready !== 1'b0 || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL read_release: grant=%b m0_ready=%b s_valid=%b, expected 00 0 0", grant, m0_ready, s_valid);
    end
  endtask

  // Both masters held, slave always ready: slot i is busy on even i, idle on odd i
  task automatic test_round_robin();
    logic [1:0] exp_g;
    int owner;
    apply_reset();
    m0_valid = 1'b1; m0_addr = 32'hA000_0000; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'hB000_0000; m1_wstrb = 4'h0;
    s_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      owner = (i / 2) % 2;
      exp_g = (i % 2 == 0) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      n_checks++;
      if (grant !== exp_g || s_valid !== (exp_g != 2'b00) || m0_ready !== exp_g[0] || m1_ready !== exp_g[1]) begin
        n_fail++;
        $display("FAIL rr_slot%0d: grant=%b s_valid=%b m0_ready=%b m1_ready=%b, expected grant %b",
                 i, grant, s_valid, m0_ready, m1_ready, exp_g);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_fixed_priority();
    logic [1:0] exp_g;
    apply_reset();
    m0_valid = 1'b1; m0_addr = 32'hA000_0004;
    m1_valid = 1'b1; m1_addr = 32'hB000_0004;
    s_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b00;
      n_checks++;
      if (fp_grant !== exp_g || fp_m1_ready !== 1'b0 || fp_m0_ready !== exp_g[0]) begin
        n_fail++;
        $display("FAIL fixed_slot%0d: grant=%b m0_ready=%b m1_ready=%b, expected grant %b",
                 i, fp_grant, fp_m0_ready, fp_m1_ready, exp_g);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write();
    m1_valid = 1'b1; m1_instr = 1'b0; m1_addr = 32'h0000_0200; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'b0011;
    step();
    n_checks++;
    if (grant !== 2'b10 || s_valid !== 1'b1 || s_addr !== 32'h200 || s_wdata !== 32'hCAFEF00D ||
        s_wstrb !== 4'b0011 || s_instr !== 1'b0 || m1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL write_payload: grant=%b s_valid=%b addr=%h wdata=%h wstrb=%b instr=%b m1_ready=%b, expected 10 1 00000200 cafef00d 0011 0 0",
               grant, s_valid, s_addr, s_wdata, s_wstrb, s_instr, m1_ready);
    end
    step();
    s_ready = 1'b1; s_rdata = 32'h0BAD_0BAD;
    #1;
    n_checks++;
    if (m1_ready !== 1'b1 || m0_ready !== 1'b0 || s_wstrb !== 4'b0011 || s_wdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL write_complete: m1_ready=%b m0_ready=%b wstrb=%b wdata=%h, expected 1 0 0011 cafef00d",
               m1_ready, m0_ready, s_wstrb, s_wdata);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_abort();
    m0_valid = 1'b1; m0_addr = 32'h0000_0300;
    step();
    step();
    m0_valid = 1'b0;
    #1;
    n_checks++;
    if (s_valid !== 1'b0 || m0_ready !== 1'b0 || grant !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_drop: s_valid=%b m0_ready=%b grant=%b, expected 0 0 01", s_valid, m0_ready, grant);
    end
    step();
    n_checks++;
    if (grant !== 2'b00 || m0_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: grant=%b m0_ready=%b, expected 00 0", grant, m0_ready);
    end
  endtask

`ifdef PRV32_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    m0_valid = 1'b1; m0_addr = 32'h0000_0400;
    // plain timeout
    step();
    early = 0;
    for (int k = 1; k < c_TOUT; k++) begin
      if (m0_ready !== 1'b0 || err_flag !== 1'b0) early++;
      step();
    end
    n_checks++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL timeout_early: %0d premature ready/err cycles, expected 0", early);
    end
    n_checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'hDEADBEEF || s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_fire: m0_ready=%b m0_rdata=%h s_valid=%b, expected 1 deadbeef 0", m0_ready, m0_rdata, s_valid);
    end
    step();
    m0_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (err_flag !== 1'b1 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_sticky: err=%b grant=%b, expected 1 00", err_flag, grant);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b, expected 0", err_flag);
    end
    // slave ready exactly at the limit wins
    m0_valid = 1'b1;
    step();
    for (int k = 1; k < c_TOUT; k++) step();
    s_ready = 1'b1; s_rdata = 32'h55AA_33CC;
    #1;
    n_checks++;
    if (m0_ready !== 1'b1 || m0_rdata !== 32'h55AA33CC) begin
      n_fail++;
      $display("FAIL timeout_ready_wins: m0_ready=%b m0_rdata=%h, expected 1 55aa33cc", m0_ready, m0_rdata);
    end
    step();
    idle_inputs();
    n_checks++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_ready_noerr: err=%b, expected 0", err_flag);
    end
    // clear coinciding with a timeout keeps the flag low
    m0_valid = 1'b1;
    step();
    for (int k = 1; k < c_TOUT; k++) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; m0_valid = 1'b0;
    n_checks++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clr_priority: err=%b, expected 0", err_flag);
    end
    step();
  endtask
`else
  task automatic test_timeout();
    int readies;
    m0_valid = 1'b1; m0_addr = 32'h0000_0400;
    readies = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m0_ready !== 1'b0 || grant !== 2'b01) readies++;
    end
    n_checks++;
    if (readies != 0) begin
      n_fail++;
      $display("FAIL no_timeout_wait: %0d cycles with ready or lost grant, expected 0", readies);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++;
    if (err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_err: err=%b, expected 0", err_flag);
    end
    m0_valid = 1'b0;
    step();
    step();
  endtask
`endif

  task automatic test_reset_mid();
    m1_valid = 1'b1; m1_addr = 32'h0000_0500;
    step();
    step();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b00 || s_valid !== 1'b0 || m1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: grant=%b s_valid=%b m1_ready=%b, expected 00 0 0", grant, s_valid, m1_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (grant !== 2'b10 || s_valid !== 1'b1 || s_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL midreset_regrant: grant=%b s_valid=%b s_addr=%h, expected 10 1 00000500", grant, s_valid, s_addr);
    end
    s_ready = 1'b1; s_rdata = 32'h7777_0001;
    #1;
    n_checks++;
    if (m1_ready !== 1'b1 || m1_rdata !== 32'h7777_0001) begin
      n_fail++;
      $display("FAIL midreset_complete: m1_ready=%b m1_rdata=%h, expected 1 77770001", m1_ready, m1_rdata);
    end
    step();
    idle_inputs();
    step();
  endtask

  // Random request mixes; losing requests stay pending into the next round
  task automatic test_random();
    bit          pend [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  st [2];
    logic        ins [2];
    int          last, win, los, dly;
    logic [31:0] rd;
    apply_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    last = 1;
    for (int it = 0; it < 60; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 1) == 1 || (m == 1 && !pend[0]))) begin
          pend[m] = 1'b1;
          a[m] = $urandom; d[m] = $urandom;
          st[m] = 4'($urandom_range(0, 15)); ins[m] = 1'($urandom_range(0, 1));
        end
      end
      m0_valid = pend[0]; m0_addr = a[0]; m0_wdata = d[0]; m0_wstrb = st[0]; m0_instr = ins[0];
      m1_valid = pend[1]; m1_addr = a[1]; m1_wdata = d[1]; m1_wstrb = st[1]; m1_instr = ins[1];
      if (pend[0] && pend[1]) win = (last == 0) ? 1 : 0;
      else win = pend[1] ? 1 : 0;
      los = 1 - win;
      step();
      n_checks++;
      if (grant !== ((win == 1) ? 2'b10 : 2'b01) || s_valid !== 1'b1 || s_addr !== a[win] ||
          s_wdata !== d[win] || s_wstrb !== st[win] || s_instr !== ins[win]) begin
        n_fail++;
        $display("FAIL rand%0d_grant: grant=%b s_valid=%b addr=%h wdata=%h wstrb=%b instr=%b, expected owner m%0d addr=%h wdata=%h wstrb=%b instr=%b",
                 it, grant, s_valid, s_addr, s_wdata, s_wstrb, s_instr, win, a[win], d[win], st[win], ins[win]);
      end
      dly = $urandom_range(0, 3);
      for (int k = 0; k < dly; k++) begin
        n_checks++;
        if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL rand%0d_wait: m0_ready=%b m1_ready=%b, expected 0 0", it, m0_ready, m1_ready);
        end
        step();
      end
      rd = $urandom;
      s_ready = 1'b1; s_rdata = rd;
      #1;
      n_checks++;
      if (((win == 0) ? m0_ready : m1_ready) !== 1'b1 || ((win == 0) ? m0_rdata : m1_rdata) !== rd ||
          ((los == 0) ? m0_ready : m1_ready) !== 1'b0 || ((los == 0) ? m0_rdata : m1_rdata) !== 32'h0) begin
        n_fail++;
        $display("FAIL rand%0d_done: m0_ready=%b m0_rdata=%h m1_ready=%b m1_rdata=%h, expected m%0d ready with %h",
                 it, m0_ready, m0_rdata, m1_ready, m1_rdata, win, rd);
      end
      step();
      s_ready = 1'b0;
      pend[win] = 1'b0;
      last = win;
      m0_valid = pend[0]; m1_valid = pend[1];
      #1;
      n_checks++;
      if (grant !== 2'b00 || s_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_bubble: grant=%b s_valid=%b, expected 00 0", it, grant, s_valid);
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
